// File: rtl/ex_operand_stage_if.sv
`default_nettype none
// =============================================================================
// ex_operand_stage_if
// Decode, forwarding-bus and EX-stage signal bundle for ex_operand_stage.
// Revision: 1.0
// =============================================================================
interface ex_operand_stage_if #(
    parameter int XLEN = 32
);
    logic            id_valid;
    logic [3:0]      id_op;
    logic [2:0]      id_funct3;
    logic            id_funct7b5;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic [4:0]      id_rd;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic [XLEN-1:0] id_pc;
    logic            mem_we;
    logic [4:0]      mem_rd;
    logic [XLEN-1:0] mem_result;
    logic            wb_we;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_result;
    logic            ex_stall;
    logic            ex_flush;
    logic            hazard_stall;
    logic            ex_valid;
    logic [3:0]      ex_op;
    logic [2:0]      ex_funct3;
    logic [4:0]      ex_rd;
    logic [XLEN-1:0] ex_pc;
    logic            ex_we;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [3:0]      alu_sel;
    logic [XLEN-1:0] ex_store_data;

    modport master (
        output id_valid, id_op, id_funct3, id_funct7b5, id_rs1, id_rs2, id_rd,
               id_rs1_data, id_rs2_data, id_imm, id_pc,
               mem_we, mem_rd, mem_result, wb_we, wb_rd, wb_result,
               ex_stall, ex_flush,
        input  hazard_stall, ex_valid, ex_op, ex_funct3, ex_rd, ex_pc, ex_we,
               alu_a, alu_b, alu_sel, ex_store_data
    );

    modport slave (
        input  id_valid, id_op, id_funct3, id_funct7b5, id_rs1, id_rs2, id_rd,
               id_rs1_data, id_rs2_data, id_imm, id_pc,
               mem_we, mem_rd, mem_result, wb_we, wb_rd, wb_result,
               ex_stall, ex_flush,
        output hazard_stall, ex_valid, ex_op, ex_funct3, ex_rd, ex_pc, ex_we,
               alu_a, alu_b, alu_sel, ex_store_data
    );
endinterface
`default_nettype wire

// File: rtl/ex_operand_stage.sv
`default_nettype none
// =============================================================================
// ex_operand_stage
// ID/EX register with operand forwarding, ALU operand select and load-use
// hazard detection. Define EX_FWD_EN to enable EX/MEM and MEM/WB forwarding.
// Revision: 1.0
// =============================================================================
module ex_operand_stage #(
    parameter int XLEN = 32
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    ex_operand_stage_if.slave bus
);
    localparam logic [3:0] c_OP_OP     = 4'd0;
    localparam logic [3:0] c_OP_IMM    = 4'd1;
    localparam logic [3:0] c_OP_LUI    = 4'd2;
    localparam logic [3:0] c_OP_AUIPC  = 4'd3;
    localparam logic [3:0] c_OP_JAL    = 4'd4;
    localparam logic [3:0] c_OP_JALR   = 4'd5;
    localparam logic [3:0] c_OP_BRANCH = 4'd6;
    localparam logic [3:0] c_OP_LOAD   = 4'd7;
    localparam logic [3:0] c_OP_STORE  = 4'd8;

    localparam logic [3:0] c_SEL_ADD  = 4'd0;
    localparam logic [3:0] c_SEL_SLT  = 4'd2;
    localparam logic [3:0] c_SEL_SUB  = 4'd8;
    localparam logic [3:0] c_SEL_SLTU = 4'd10;

    function automatic logic f_legal(input logic [3:0] op);
        return op <= c_OP_STORE;
    endfunction

    function automatic logic f_reads_rs1(input logic [3:0] op);
        return f_legal(op) && (op != c_OP_LUI) && (op != c_OP_AUIPC) && (op != c_OP_JAL);
    endfunction

    function automatic logic f_reads_rs2(input logic [3:0] op);
        return (op == c_OP_OP) || (op == c_OP_BRANCH) || (op == c_OP_STORE);
    endfunction

    function automatic logic f_writes(input logic [3:0] op);
        return (op == c_OP_OP) || (op == c_OP_IMM) || (op == c_OP_LUI) ||
               (op == c_OP_AUIPC) || (op == c_OP_JAL) || (op == c_OP_JALR) ||
               (op == c_OP_LOAD);
    endfunction

    logic            valid_q,    valid_d;
    logic [3:0]      op_q,       op_d;
    logic [2:0]      funct3_q,   funct3_d;
    logic            funct7b5_q, funct7b5_d;
    logic [4:0]      rs1_q,      rs1_d;
    logic [4:0]      rs2_q,      rs2_d;
    logic [4:0]      rd_q,       rd_d;
    logic [XLEN-1:0] rs1_data_q, rs1_data_d;
    logic [XLEN-1:0] rs2_data_q, rs2_data_d;
    logic [XLEN-1:0] imm_q,      imm_d;
    logic [XLEN-1:0] pc_q,       pc_d;

    logic            w_ex_we;
    logic            w_hazard;
    logic [XLEN-1:0] w_rs1f;
    logic [XLEN-1:0] w_rs2f;

    // True when the instruction in decode reads register rd (x0 never matches).
    function automatic logic f_id_uses(input logic [4:0] rd);
        return (rd != 5'd0) && bus.id_valid &&
               ((f_reads_rs1(bus.id_op) && (bus.id_rs1 == rd)) ||
                (f_reads_rs2(bus.id_op) && (bus.id_rs2 == rd)));
    endfunction

    assign w_ex_we = valid_q && f_writes(op_q) && (rd_q != 5'd0);

`ifdef EX_FWD_EN
    function automatic logic [XLEN-1:0] f_fwd(input logic [4:0] rs, input logic [XLEN-1:0] rdata);
        if (bus.mem_we && (bus.mem_rd == rs) && (rs != 5'd0)) begin
            return bus.mem_result;
        end else if (bus.wb_we && (bus.wb_rd == rs) && (rs != 5'd0)) begin
            return bus.wb_result;
        end
        return rdata;
    endfunction

    assign w_rs1f   = f_fwd(rs1_q, rs1_data_q);
    assign w_rs2f   = f_fwd(rs2_q, rs2_data_q);
    assign w_hazard = valid_q && (op_q == c_OP_LOAD) && f_id_uses(rd_q);
`else
    // Without forwarding, any pending write to a source register must drain first.
    assign w_rs1f   = rs1_data_q;
    assign w_rs2f   = rs2_data_q;
    assign w_hazard = (valid_q && (op_q == c_OP_LOAD) && f_id_uses(rd_q)) ||
                      (w_ex_we && f_id_uses(rd_q)) ||
                      (bus.mem_we && f_id_uses(bus.mem_rd)) ||
                      (bus.wb_we && f_id_uses(bus.wb_rd));
`endif

    always_comb begin
        valid_d    = valid_q;
        op_d       = op_q;
        funct3_d   = funct3_q;
        funct7b5_d = funct7b5_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        pc_d       = pc_q;
        if (bus.ex_flush) begin
            valid_d = 1'b0;
        end else if (bus.ex_stall) begin
            valid_d = valid_q;
        end else if (w_hazard) begin
            valid_d = 1'b0;
        end else begin
            valid_d    = bus.id_valid && f_legal(bus.id_op);
            op_d       = bus.id_op;
            funct3_d   = bus.id_funct3;
            funct7b5_d = bus.id_funct7b5;
            rs1_d      = bus.id_rs1;
            rs2_d      = bus.id_rs2;
            rd_d       = bus.id_rd;
            rs1_data_d = bus.id_rs1_data;
            rs2_data_d = bus.id_rs2_data;
            imm_d      = bus.id_imm;
            pc_d       = bus.id_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            op_q       <= '0;
            funct3_q   <= '0;
            funct7b5_q <= 1'b0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            pc_q       <= '0;
        end else begin
            valid_q    <= valid_d;
            op_q       <= op_d;
            funct3_q   <= funct3_d;
            funct7b5_q <= funct7b5_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            pc_q       <= pc_d;
        end
    end

    always_comb begin
        bus.alu_a   = '0;
        bus.alu_b   = '0;
        bus.alu_sel = c_SEL_ADD;
        if (valid_q) begin
            case (op_q)
                c_OP_OP: begin
                    bus.alu_a   = w_rs1f;
                    bus.alu_b   = w_rs2f;
                    bus.alu_sel = {funct7b5_q, funct3_q};
                end
                c_OP_IMM: begin
                    bus.alu_a   = w_rs1f;
                    bus.alu_b   = imm_q;
                    // Only the shift-right immediates carry a meaningful f7b5 bit.
                    bus.alu_sel = (funct3_q == 3'd5) ? {funct7b5_q, funct3_q} : {1'b0, funct3_q};
                end
                c_OP_LUI: begin
                    bus.alu_b = imm_q;
                end
                c_OP_AUIPC: begin
                    bus.alu_a = pc_q;
                    bus.alu_b = imm_q;
                end
                c_OP_JAL, c_OP_JALR: begin
                    bus.alu_a = pc_q;
                    bus.alu_b = XLEN'(4);
                end
                c_OP_BRANCH: begin
                    bus.alu_a = w_rs1f;
                    bus.alu_b = w_rs2f;
                    case (funct3_q[2:1])
                        2'b10:   bus.alu_sel = c_SEL_SLT;
                        2'b11:   bus.alu_sel = c_SEL_SLTU;
                        default: bus.alu_sel = c_SEL_SUB;
                    endcase
                end
                c_OP_LOAD, c_OP_STORE: begin
                    bus.alu_a = w_rs1f;
                    bus.alu_b = imm_q;
                end
                default: begin
                    bus.alu_sel = c_SEL_ADD;
                end
            endcase
        end
    end

    assign bus.hazard_stall  = w_hazard;
    assign bus.ex_valid      = valid_q;
    assign bus.ex_op         = op_q;
    assign bus.ex_funct3     = funct3_q;
    assign bus.ex_rd         = rd_q;
    assign bus.ex_pc         = pc_q;
    assign bus.ex_we         = w_ex_we;
    assign bus.ex_store_data = w_rs2f;

endmodule
`default_nettype wire

// File: tb/tb_ex_operand_stage.sv
`default_nettype none
// =============================================================================
// tb_ex_operand_stage
// Scoreboard bench: stimulus pushes expected EX-stage outputs, monitor compares.
// Revision: 1.0
// =============================================================================
module tb_ex_operand_stage;
`ifdef EX_FWD_EN
    localparam bit c_FWD = 1'b1;
`else
    localparam bit c_FWD = 1'b0;
`endif

    typedef struct {
        string       name;
        logic        v;
        logic        we;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  sel;
        logic [31:0] st;
        logic        hz;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;
    exp_t sb[$];

    ex_operand_stage_if #(.XLEN(32)) bus ();

    ex_operand_stage #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input string n, input logic v, input logic we,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [3:0] sel, input logic [31:0] st, input logic hz);
        exp_t e;
        e.name = n; e.v = v; e.we = we; e.a = a; e.b = b; e.sel = sel; e.st = st; e.hz = hz;
        return e;
    endfunction

    task automatic chk(input string n, input string fld, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %h, expected %h", n, fld, act, exp);
        end
    endtask

    // Monitor: compares every pending expectation at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                chk(e.name, "ex_valid",   {31'd0, bus.ex_valid},     {31'd0, e.v});
                chk(e.name, "ex_we",      {31'd0, bus.ex_we},        {31'd0, e.we});
                chk(e.name, "alu_a",      bus.alu_a,                 e.a);
                chk(e.name, "alu_b",      bus.alu_b,                 e.b);
                chk(e.name, "alu_sel",    {28'd0, bus.alu_sel},      {28'd0, e.sel});
                chk(e.name, "store_data", bus.ex_store_data,         e.st);
                chk(e.name, "hazard",     {31'd0, bus.hazard_stall}, {31'd0, e.hz});
            end
        end
    end

    task automatic step(input exp_t e);
        @(posedge clk);
        #1;
        sb.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [3:0] op, input logic [2:0] f3, input logic f7,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] imm, input logic [31:0] pc);
        bus.id_valid = v;    bus.id_op = op;     bus.id_funct3 = f3; bus.id_funct7b5 = f7;
        bus.id_rs1 = rs1;    bus.id_rs2 = rs2;   bus.id_rd = rd;
        bus.id_rs1_data = d1; bus.id_rs2_data = d2; bus.id_imm = imm; bus.id_pc = pc;
    endtask

    task automatic set_fwd(input logic mwe, input logic [4:0] mrd, input logic [31:0] mres,
                           input logic wwe, input logic [4:0] wrd, input logic [31:0] wres);
        bus.mem_we = mwe; bus.mem_rd = mrd; bus.mem_result = mres;
        bus.wb_we = wwe;  bus.wb_rd = wrd;  bus.wb_result = wres;
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst_n = 1'b0;
        bus.ex_stall = 1'b0;
        bus.ex_flush = 1'b0;
        set_id(0, 4'd0, 3'd0, 0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        set_fwd(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        step(mk("reset", 0, 0, 32'd0, 32'd0, 4'd0, 32'd0, 0));
        rst_n = 1'b1;

        set_id(1, 4'd0, 3'd0, 1, 5'd1, 5'd2, 5'd3, 32'd10, 32'd3, 32'd0, 32'h40);
        step(mk("op_sub", 1, 1, 32'd10, 32'd3, 4'd8, 32'd3, 0));
        set_id(1, 4'd1, 3'd5, 1, 5'd4, 5'd0, 5'd5, 32'h8000_0000, 32'd0, 32'd4, 32'h44);
        step(mk("srai", 1, 1, 32'h8000_0000, 32'd4, 4'd13, 32'd0, 0));
        set_id(1, 4'd1, 3'd0, 1, 5'd4, 5'd0, 5'd6, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'h48);
        step(mk("addi_f7b5", 1, 1, 32'd7, 32'hFFFF_FFFF, 4'd0, 32'd0, 0));
        set_id(1, 4'd2, 3'd0, 0, 5'd0, 5'd0, 5'd7, 32'd0, 32'd0, 32'h1234_5000, 32'h4C);
        step(mk("lui", 1, 1, 32'd0, 32'h1234_5000, 4'd0, 32'd0, 0));
        set_id(1, 4'd3, 3'd0, 0, 5'd0, 5'd0, 5'd8, 32'd0, 32'd0, 32'h2000, 32'h100);
        step(mk("auipc", 1, 1, 32'h100, 32'h2000, 4'd0, 32'd0, 0));
        set_id(1, 4'd4, 3'd0, 0, 5'd0, 5'd0, 5'd1, 32'd0, 32'd0, 32'h80, 32'h200);
        step(mk("jal", 1, 1, 32'h200, 32'd4, 4'd0, 32'd0, 0));
        set_id(1, 4'd5, 3'd0, 0, 5'd9, 5'd0, 5'd0, 32'h55, 32'd0, 32'd0, 32'h300);
        step(mk("jalr_x0", 1, 0, 32'h300, 32'd4, 4'd0, 32'd0, 0));
        set_id(1, 4'd6, 3'd6, 0, 5'd1, 5'd2, 5'd0, 32'd1, 32'hFFFF_FFFF, 32'h10, 32'h304);
        step(mk("bltu", 1, 0, 32'd1, 32'hFFFF_FFFF, 4'd10, 32'hFFFF_FFFF, 0));
        set_id(1, 4'd6, 3'd0, 0, 5'd1, 5'd2, 5'd0, 32'd5, 32'd5, 32'h10, 32'h308);
        step(mk("beq", 1, 0, 32'd5, 32'd5, 4'd8, 32'd5, 0));
        set_id(1, 4'd6, 3'd5, 0, 5'd1, 5'd2, 5'd0, 32'd5, 32'd6, 32'h10, 32'h30C);
        step(mk("bge", 1, 0, 32'd5, 32'd6, 4'd2, 32'd6, 0));
        set_id(1, 4'd8, 3'd2, 0, 5'd3, 5'd4, 5'd0, 32'h1000, 32'hCAFE, 32'd8, 32'h310);
        step(mk("store", 1, 0, 32'h1000, 32'd8, 4'd0, 32'hCAFE, 0));
        set_id(1, 4'd9, 3'd0, 0, 5'd1, 5'd2, 5'd3, 32'h77, 32'd0, 32'h99, 32'h314);
        step(mk("illegal_op", 0, 0, 32'd0, 32'd0, 4'd0, 32'd0, 0));

        // Forwarding observed while the instruction is held by ex_stall.
        set_id(1, 4'd0, 3'd0, 0, 5'd5, 5'd6, 5'd10, 32'h100, 32'h200, 32'd0, 32'h318);
        step(mk("fwd_base", 1, 1, 32'h100, 32'h200, 4'd0, 32'h200, 0));
        bus.ex_stall = 1'b1;
        bus.id_valid = 1'b0;
        set_fwd(1, 5'd5, 32'h11, 1, 5'd5, 32'h22);
        step(mk("fwd_mem_prio", 1, 1, c_FWD ? 32'h11 : 32'h100, 32'h200, 4'd0, 32'h200, 0));
        set_fwd(0, 5'd5, 32'h11, 1, 5'd5, 32'h22);
        step(mk("fwd_wb", 1, 1, c_FWD ? 32'h22 : 32'h100, 32'h200, 4'd0, 32'h200, 0));
        set_fwd(1, 5'd6, 32'h33, 0, 5'd0, 32'd0);
        step(mk("fwd_rs2", 1, 1, 32'h100, c_FWD ? 32'h33 : 32'h200, 4'd0,
                c_FWD ? 32'h33 : 32'h200, 0));
        bus.ex_stall = 1'b0;
        set_fwd(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        set_id(1, 4'd0, 3'd0, 0, 5'd0, 5'd6, 5'd11, 32'd0, 32'h200, 32'd0, 32'h31C);
        step(mk("x0_base", 1, 1, 32'd0, 32'h200, 4'd0, 32'h200, 0));
        bus.ex_stall = 1'b1;
        bus.id_valid = 1'b0;
        set_fwd(1, 5'd0, 32'h11, 1, 5'd0, 32'h22);
        step(mk("x0_no_fwd", 1, 1, 32'd0, 32'h200, 4'd0, 32'h200, 0));
        bus.ex_stall = 1'b0;
        set_fwd(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);

        // Load-use: LOAD x7 in EX, decode presents LUI x7 then OP reading x7.
        set_id(1, 4'd7, 3'd2, 0, 5'd2, 5'd0, 5'd7, 32'h40, 32'd0, 32'd4, 32'h320);
        step(mk("load", 1, 1, 32'h40, 32'd4, 4'd0, 32'd0, 0));
        bus.ex_stall = 1'b1;
        set_id(1, 4'd2, 3'd0, 0, 5'd0, 5'd0, 5'd7, 32'd0, 32'd0, 32'h5000, 32'h324);
        step(mk("lui_no_hazard", 1, 1, 32'h40, 32'd4, 4'd0, 32'd0, 0));
        set_id(1, 4'd0, 3'd0, 0, 5'd1, 5'd7, 5'd12, 32'd5, 32'd9, 32'd0, 32'h328);
        step(mk("load_use_hz", 1, 1, 32'h40, 32'd4, 4'd0, 32'd0, 1));
        bus.ex_stall = 1'b0;
        step(mk("bubble", 0, 0, 32'd0, 32'd0, 4'd0, 32'd0, 0));
        step(mk("after_bubble", 1, 1, 32'd5, 32'd9, 4'd0, 32'd9, 0));

        bus.ex_flush = 1'b1;
        bus.ex_stall = 1'b1;
        step(mk("flush_stall", 0, 0, 32'd0, 32'd0, 4'd0, 32'd9, 0));
        bus.ex_flush = 1'b0;
        bus.ex_stall = 1'b0;

        set_id(1, 4'd0, 3'd0, 1, 5'd1, 5'd2, 5'd3, 32'd10, 32'd3, 32'd0, 32'h40);
        step(mk("sub_again", 1, 1, 32'd10, 32'd3, 4'd8, 32'd3, 0));
        bus.ex_stall = 1'b1;
        rst_n = 1'b0;
        step(mk("reset_mid_stall", 0, 0, 32'd0, 32'd0, 4'd0, 32'd0, 0));
        rst_n = 1'b1;
        bus.ex_stall = 1'b0;
        step(mk("first_capture", 1, 1, 32'd10, 32'd3, 4'd8, 32'd3, 0));

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
